// File: rtl/aes_inv_round_ctrl_if.sv
// Purpose : bundles the request, stage-handshake and status signals of the
//           AES inverse-round controller into one port.
// Ports   : start/ct (request), res/ry_* (stage results and readies),
//           en_*/st/rnd (stage drive), pt/busy/done/err (status).
// Latency : n/a (wiring only).
// Backpressure: n/a (wiring only).
interface aes_inv_round_ctrl_if;
  logic         start;
  logic [127:0] ct;
  logic [127:0] res;
  logic         ry_ark;
  logic         ry_isr;
  logic         ry_isb;
  logic         ry_imc;
  logic         en_ark;
  logic         en_isr;
  logic         en_isb;
  logic         en_imc;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic [127:0] pt;
  logic         busy;
  logic         done;
  logic         err;

  // Host plus external stage datapath.
  modport master (
    output start, ct, res, ry_ark, ry_isr, ry_isb, ry_imc,
    input  en_ark, en_isr, en_isb, en_imc, st, rnd, pt, busy, done, err
  );

  // The round controller.
  modport slave (
    input  start, ct, res, ry_ark, ry_isr, ry_isb, ry_imc,
    output en_ark, en_isr, en_isb, en_imc, st, rnd, pt, busy, done, err
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Purpose : sequences external AddRoundKey / InvShiftRows / InvSubBytes /
//           InvMixColumns stages through a full AES-128 decryption.
// Ports   : clk_i, rst_i (sync, active-high), bus (slave side of the interface).
// Latency : 41 edges Start-to-Done when every stage readies in its first cycle.
// Backpressure: each stage holds until its ready; a 4-bit watchdog forces ERR
//           once a stage has waited 15 cycles and is still not ready.
module aes_inv_round_ctrl (
  input  logic                  clk_i,
  input  logic                  rst_i,
  aes_inv_round_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARK, S_ISR, S_ISB, S_IMC, S_DONE, S_ERR
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   wd_q, wd_d;
  logic         ry_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      pt_q    <= '0;
      rnd_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    pt_d    = pt_q;
    rnd_d   = rnd_q;
    wd_d    = wd_q;

    // Only the ready of the stage currently enabled matters.
    case (state_q)
      S_ARK:   ry_sel = bus.ry_ark;
      S_ISR:   ry_sel = bus.ry_isr;
      S_ISB:   ry_sel = bus.ry_isb;
      S_IMC:   ry_sel = bus.ry_imc;
      default: ry_sel = 1'b0;
    endcase

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        wd_d = '0;
        if (bus.start) begin
          state_d = S_ARK;
          st_d    = bus.ct;
          rnd_d   = 4'd10;
        end
      end
      default: begin
        if (ry_sel) begin
          // Completion wins even on the cycle the watchdog would expire.
          st_d = bus.res;
          wd_d = '0;
          case (state_q)
            S_ARK: begin
              if (rnd_q == 4'd10) begin
                state_d = S_ISR;
              end else if (rnd_q == 4'd0) begin
                state_d = S_DONE;
                pt_d    = bus.res;
              end else begin
                state_d = S_IMC;
              end
              if (rnd_q != 4'd0) rnd_d = rnd_q - 4'd1;
            end
            S_ISR:   state_d = S_ISB;
            S_ISB:   state_d = S_ARK;
            S_IMC:   state_d = S_ISR;
            default: state_d = state_q;
          endcase
        end else if (wd_q == 4'd15) begin
          state_d = S_ERR;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + 4'd1;
        end
      end
    endcase
  end

  assign bus.en_ark = (state_q == S_ARK);
  assign bus.en_isr = (state_q == S_ISR);
  assign bus.en_isb = (state_q == S_ISB);
  assign bus.en_imc = (state_q == S_IMC);
  assign bus.busy   = (state_q == S_ARK) || (state_q == S_ISR) ||
                      (state_q == S_ISB) || (state_q == S_IMC);
  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = (state_q == S_ERR);
  assign bus.st     = st_q;
  assign bus.rnd    = rnd_q;
  assign bus.pt     = pt_q;

endmodule
